// File: rtl/tile_writer_if.sv
// rtl/tile_writer_if.sv - input word stream and buffer write port bundle for tile_writer
//
// Ports carried:
//   in_data/in_valid/in_ready : word stream from the compute datapath
//   wr_en/wr_addr/wr_data/wr_mask : single-cycle buffer write port
// Modports:
//   master : the datapath/buffer side (drives the stream, observes writes)
//   slave  : tile_writer itself
interface tile_writer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
);
  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [LANES-1:0]      wr_mask;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, wr_mask
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, wr_mask
  );
endinterface

// File: rtl/tile_writer.sv
// rtl/tile_writer.sv - stores a per-channel strided tile from a word stream into the output buffer
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous abort, returns to IDLE without done
//   start        : one-cycle pulse, latches the tile config below
//   row_len      : elements (bytes) per channel row
//   base_addr_wr : word address of channel 0, word 0
//   stride_chan  : word address step between channels
//   chan_num     : number of channels
//   bus          : input stream + buffer write port (tile_writer_if.slave)
//   busy         : tile in progress (RUN or FIN)
//   done         : one-cycle pulse with the final write
module tile_writer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  start,
  input  logic [5:0]            row_len,
  input  logic [ADDR_WIDTH-1:0] base_addr_wr,
  input  logic [ADDR_WIDTH-1:0] stride_chan,
  input  logic [9:0]            chan_num,
  tile_writer_if.slave          bus,
  output logic                  busy,
  output logic                  done
);
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] stride_q;
  logic [ADDR_WIDTH-1:0] chan_base_q;
  logic [9:0]            chan_num_q;
  logic [9:0]            chan_idx_q;
  logic [5:0]            wpr_q;
  logic [5:0]            word_idx_q;
  logic [LANES-1:0]      tail_mask_q;

  logic [5:0]       wpr_d;
  logic [5:0]       rem_d;
  logic [LANES-1:0] tail_mask_d;
  logic             xfer;
  logic             last_word;
  logic             last_chan;

  // Row geometry derived from row_len at start; only these derived values are kept.
  always_comb begin
    wpr_d = 6'((32'(row_len) + LANES - 1) / LANES);
    rem_d = 6'(32'(row_len) % LANES);
    tail_mask_d = '0;
    for (int i = 0; i < LANES; i++) begin
      // A row that fills its last word exactly gets a full mask.
      tail_mask_d[i] = (rem_d == 6'd0) || (i < int'(rem_d));
    end
  end

  assign xfer      = (state_q == S_RUN) && bus.in_valid;
  assign last_word = (word_idx_q == wpr_q - 6'd1);
  assign last_chan = (chan_idx_q == chan_num_q - 10'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (row_len == 6'd0 || chan_num == 10'd0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        if (xfer && last_word && last_chan) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q     <= '0;
      chan_base_q  <= '0;
      chan_num_q   <= '0;
      chan_idx_q   <= '0;
      wpr_q        <= '0;
      word_idx_q   <= '0;
      tail_mask_q  <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      bus.wr_mask  <= '0;
    end else if (clr) begin
      // Aborting drops any write that this cycle's transfer would have scheduled.
      stride_q     <= '0;
      chan_base_q  <= '0;
      chan_num_q   <= '0;
      chan_idx_q   <= '0;
      wpr_q        <= '0;
      word_idx_q   <= '0;
      tail_mask_q  <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      bus.wr_mask  <= '0;
    end else begin
      bus.wr_en <= xfer;
      if (state_q == S_IDLE && start) begin
        stride_q    <= stride_chan;
        chan_base_q <= base_addr_wr;
        chan_num_q  <= chan_num;
        chan_idx_q  <= '0;
        wpr_q       <= wpr_d;
        word_idx_q  <= '0;
        tail_mask_q <= tail_mask_d;
      end else if (xfer) begin
        bus.wr_addr <= chan_base_q + ADDR_WIDTH'(word_idx_q);
        bus.wr_data <= bus.in_data;
        bus.wr_mask <= last_word ? tail_mask_q : {LANES{1'b1}};
        if (last_word) begin
          word_idx_q  <= '0;
          chan_base_q <= chan_base_q + stride_q;
          chan_idx_q  <= chan_idx_q + 10'd1;
        end else begin
          word_idx_q  <= word_idx_q + 6'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tile_writer.sv
// tb/tb_tile_writer.sv - directed self-checking bench for tile_writer
module tb_tile_writer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       start;
  logic [5:0] row_len;
  logic [7:0] base_addr_wr;
  logic [7:0] stride_chan;
  logic [9:0] chan_num;
  logic       busy;
  logic       done;

  tile_writer_if #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) bus ();

  tile_writer #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .start        (start),
    .row_len      (row_len),
    .base_addr_wr (base_addr_wr),
    .stride_chan  (stride_chan),
    .chan_num     (chan_num),
    .bus          (bus),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  exp_addr  [0:7];
  logic [7:0]  exp_mask  [0:7];
  logic [63:0] sent_data [0:7];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_basic();
    exp_addr[0] = 8'd32; exp_addr[1] = 8'd33; exp_addr[2] = 8'd34;
    exp_addr[3] = 8'd36; exp_addr[4] = 8'd37; exp_addr[5] = 8'd38;
    exp_mask[0] = 8'hFF; exp_mask[1] = 8'hFF; exp_mask[2] = 8'h03;
    exp_mask[3] = 8'hFF; exp_mask[4] = 8'hFF; exp_mask[5] = 8'h03;
  endtask

  // gap: in_valid offered every gap-th cycle; abort_after: clr after that many
  // transfers (-1 = never); restart_at: cycle of an ignored mid-tile start (-1 = none).
  task automatic run_tile(input logic [5:0] rl, input logic [7:0] base, input logic [7:0] stride,
                          input logic [9:0] cn, input int n_exp, input int gap,
                          input int abort_after, input int restart_at);
    int   sent;
    int   wr;
    logic prev_xfer;
    logic running;
    logic exp_done;
    logic finished;
    logic [7:0] b;
    start = 1'b1; row_len = rl; base_addr_wr = base; stride_chan = stride; chan_num = cn;
    tick();
    start = 1'b0;
    if (n_exp == 0) begin
      check("deg_done", done, 1);
      check("deg_busy", busy, 1);
      check("deg_in_ready", bus.in_ready, 0);
      check("deg_wr_en", bus.wr_en, 0);
      tick();
      check("deg_done_fall", done, 0);
      check("deg_busy_fall", busy, 0);
      check("deg_in_ready2", bus.in_ready, 0);
      check("deg_wr_en2", bus.wr_en, 0);
      return;
    end
    sent = 0; wr = 0; prev_xfer = 1'b0; finished = 1'b0;
    for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
      start = 1'b0;
      check("wr_en", bus.wr_en, prev_xfer);
      exp_done = 1'b0;
      if (prev_xfer) begin
        check("wr_addr", bus.wr_addr, exp_addr[wr]);
        check("wr_mask", bus.wr_mask, exp_mask[wr]);
        check("wr_data", bus.wr_data, sent_data[wr]);
        wr++;
        exp_done = (wr == n_exp);
      end
      running = (sent < n_exp);
      check("done", done, exp_done);
      check("in_ready", bus.in_ready, running);
      check("busy", busy, running || exp_done);
      if (exp_done) begin
        finished = 1'b1;
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = running && (cyc % gap == 0);
        if (abort_after >= 0 && sent == abort_after && bus.in_valid) begin
          bus.in_data = 64'hDEAD_BEEF_0000_0000;
          clr = 1'b1;
          tick();
          clr = 1'b0;
          bus.in_valid = 1'b0;
          check("abort_wr_en", bus.wr_en, 0);
          check("abort_busy", busy, 0);
          check("abort_in_ready", bus.in_ready, 0);
          check("abort_done", done, 0);
          check("abort_wr_addr", bus.wr_addr, 0);
          check("abort_wr_mask", bus.wr_mask, 0);
          tick();
          check("abort_done2", done, 0);
          check("abort_busy2", busy, 0);
          return;
        end
        if (bus.in_valid) begin
          b = 8'(sent * 17 + 1);
          bus.in_data = 64'h0123_4567_89AB_CDEF ^ {8{b}};
          sent_data[sent] = bus.in_data;
          sent++;
        end
        prev_xfer = bus.in_valid;
        if (cyc == restart_at) begin
          start = 1'b1; base_addr_wr = 8'd100; row_len = 6'd8; chan_num = 10'd1;
        end
        tick();
      end
    end
    if (!finished) check("timeout", 0, 1);
    bus.in_valid = 1'b0;
    start = 1'b0;
    tick();
    check("end_busy", busy, 0);
    check("end_done", done, 0);
    check("end_wr_en", bus.wr_en, 0);
    check("end_in_ready", bus.in_ready, 0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; start = 1'b0;
    row_len = '0; base_addr_wr = '0; stride_chan = '0; chan_num = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_wr_mask", bus.wr_mask, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    tick();

    load_basic();
    run_tile(6'd18, 8'd32, 8'd4, 10'd2, 6, 1, -1, -1);
    run_tile(6'd18, 8'd32, 8'd4, 10'd2, 6, 3, -1, -1);

    exp_addr[0] = 8'd254; exp_addr[1] = 8'd2;
    exp_mask[0] = 8'hFF;  exp_mask[1] = 8'hFF;
    run_tile(6'd8, 8'd254, 8'd4, 10'd2, 2, 1, -1, -1);

    run_tile(6'd18, 8'd32, 8'd4, 10'd0, 0, 1, -1, -1);
    run_tile(6'd0, 8'd32, 8'd4, 10'd2, 0, 1, -1, -1);

    load_basic();
    run_tile(6'd18, 8'd32, 8'd4, 10'd2, 6, 1, 2, -1);
    run_tile(6'd18, 8'd32, 8'd4, 10'd2, 6, 1, -1, -1);
    run_tile(6'd18, 8'd32, 8'd4, 10'd2, 6, 1, -1, 2);

    start = 1'b1; clr = 1'b1; row_len = 6'd18; base_addr_wr = 8'd32; chan_num = 10'd2;
    tick();
    start = 1'b0; clr = 1'b0;
    check("clr_start_busy", busy, 0);
    check("clr_start_in_ready", bus.in_ready, 0);
    check("clr_start_done", done, 0);
    tick();
    check("clr_start_busy2", busy, 0);
    check("clr_start_done2", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tile_writer.md
Name: tile_writer

Overview:
tile_writer is the write-back counterpart of tile_mover. tile_mover reads tile rows out of the buffer; tile_writer takes tile rows from the compute datapath and stores them into the output buffer.
- Input side: a valid/ready word stream.
- Output side: a per-channel strided tile of DATA_WIDTH-wide words, written through a single-cycle write port.
- Partial last words carry a lane mask.
- done pulses when the whole tile (all channels) has been written.

Parameters:
DATA_WIDTH, 64, bits per buffer word; must be a multiple of 8
ADDR_WIDTH, 8, buffer address width
LANES, DATA_WIDTH/8, 8-bit elements per word (derived, not overridable)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear; aborts any operation
start  input  1  one-cycle pulse; latches config, begins tile
row_len  input  6  elements per channel row (8-bit elements)
base_addr_wr  input  ADDR_WIDTH  write address of channel 0, word 0
stride_chan  input  ADDR_WIDTH  address increment between channels
chan_num  input  10  number of channels
in_data  input  DATA_WIDTH  word from compute datapath
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data this cycle
wr_en  output  1  buffer write strobe
wr_addr  output  ADDR_WIDTH  buffer write address
wr_data  output  DATA_WIDTH  buffer write data
wr_mask  output  LANES  per-element write enable
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; all outputs 0; all counters 0.
- States:
  - IDLE: wait for start.
  - RUN: accept input words and issue writes.
  - FIN: one cycle; done=1; then back to IDLE.
- IDLE, start=1:
  - Latch row_len, base_addr_wr, stride_chan, chan_num.
  - Compute words_per_row = ceil(row_len/LANES).
  - If row_len==0 or chan_num==0, go to FIN; no writes occur; done is high the cycle after start.
  - Otherwise go to RUN.
- start while busy is ignored. Inputs are sampled only at start; later changes have no effect.
- busy=1 in RUN and FIN.
- in_ready=1 exactly in RUN (combinational from state).
- Handshake: a word transfers on in_valid&&in_ready. in_valid gaps stall the block with no other effect.
- Write timing: a transfer at cycle N produces, at cycle N+1, wr_en=1 with:
  - wr_addr = chan_base + word_idx
  - wr_data = in_data captured at cycle N
  - wr_mask as defined below
- Registered write outputs: wr_en=0 in any cycle with no preceding transfer. wr_addr, wr_data and wr_mask hold their last values when wr_en=0.
- Address arithmetic:
  - chan_base starts at base_addr_wr and increments by stride_chan after the last word of each channel.
  - word_idx runs 0..words_per_row-1 and resets to 0 at each channel boundary.
  - All sums are modulo 2^ADDR_WIDTH (wrap, no error).
  - stride_chan < words_per_row (overlapping channels) is legal; writes are issued as computed.
- Mask:
  - wr_mask = all ones, except on the last word of each row when row_len%LANES != 0.
  - In that case wr_mask = (1<<(row_len%LANES))-1, with bit 0 = lowest-order byte lane.
- Completion:
  - The transfer of the final word (last word of channel chan_num-1) moves the state RUN->FIN.
  - The final wr_en and done are asserted in the same cycle.
  - in_ready drops the cycle after the final transfer.
- clr=1 (synchronous, highest priority after reset):
  - Next state IDLE; counters cleared; wr_en, busy, in_ready, done = 0 the next cycle.
  - A write scheduled from a same-cycle transfer is dropped.
  - done is not asserted for an aborted tile.
- start and clr in the same cycle: clr wins, and the block stays IDLE.
- Total number of writes per tile = chan_num * words_per_row.

Test Plan:
1. Basic tile: row_len=18, base=32, stride=4, chan_num=2, in_valid held high -> 6 writes on consecutive cycles:
   - wr_addr 32,33,34,36,37,38
   - wr_mask FF,FF,03,FF,FF,03
   - done high with the write to 38; busy falls the next cycle.
2. Backpressure: same config, in_valid high only every third cycle -> same address/mask/data sequence. Each wr_en follows its transfer by exactly 1 cycle; no writes in gap cycles.
3. Exact multiple and wrap: row_len=8, base=254, stride=4, chan_num=2 -> writes to 254 then 2; both masks FF; done with the second write.
4. Degenerate config: chan_num=0 (then separately row_len=0) -> no wr_en, in_ready never high, done pulses 1 cycle after start.
5. Abort and restart: clr asserted after 2 of 6 transfers in scenario 1 -> next cycle all outputs 0 and no done. A fresh start then reproduces scenario 1 from address 32.
6. Ignored start: a second start with base=100 mid-tile -> addresses continue per scenario 1; no restart; a single done.
